sorted_insert_writer: RTL and testbench

Write-side companion to the binary-search reader. It accepts one W-bit value per valid/ready handshake and inserts it into a single-port synchronous RAM. Larger stored entries are shifted up one slot, so `mem[0..count-1]` stays sorted ascending at all times. The binary-search block reads the same RAM once `busy` is low.

---
 rtl/binsearch_pkg.sv | 15 +
 rtl/sorted_ram.sv | 29 ++
 rtl/sorted_insert_writer.sv | 118 +++++++++++
 tb/tb_sorted_insert_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/binsearch_pkg.sv
// Shared definitions for the sorted-RAM writer and the binary-search reader.
package binsearch_pkg;

  localparam int unsigned DEF_N    = 32;
  localparam int unsigned DEF_LOGN = 5;
  localparam int unsigned DEF_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CMP   = 2'd2,
    PLACE = 2'd3
  } state_t;

endpackage

// File: rtl/sorted_ram.sv
// Single-port N x W RAM with registered read (read-before-write on the same address).
module sorted_ram
  import binsearch_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned LOGN = DEF_LOGN,
  parameter int unsigned W    = DEF_W
) (
  input  logic            clk,
  input  logic [LOGN-1:0] addr,
  input  logic            wr_en,
  input  logic [W-1:0]    wr_data,
  output logic [W-1:0]    rd_data
);

  logic [W-1:0] mem [N];
  logic [W-1:0] rd_data_q;

  // Write when strobed; the read port always returns the old contents a cycle later.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
    rd_data_q <= mem[addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sorted_insert_writer.sv
// Inserts one value per handshake into a sorted RAM, shifting larger entries up a slot.
module sorted_insert_writer
  import binsearch_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned LOGN = DEF_LOGN,
  parameter int unsigned W    = DEF_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [W-1:0]    in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            clear,
  output logic [LOGN-1:0] mem_addr,
  output logic            mem_wr_en,
  output logic [W-1:0]    mem_wr_data,
  input  logic [W-1:0]    mem_rd_data,
  output logic [LOGN:0]   count,
  output logic            full,
  output logic            busy,
  output logic            done
);

  localparam logic [LOGN:0] FULL_CNT = (LOGN+1)'(N);
  localparam logic [LOGN:0] ONE      = (LOGN+1)'(1);

  state_t          state_q, state_d;
  logic [W-1:0]    v_q, v_d;
  logic [LOGN:0]   i_q, i_d;
  logic [LOGN:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            accept;

  // Next-state, datapath updates and RAM port drive for the insertion walk.
  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    i_d         = i_q;
    count_d     = count_q;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    done        = 1'b0;
    in_ready    = 1'b0;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = !full_q && !clear;
        accept   = in_valid && in_ready;
        if (clear) begin
          count_d = '0;
        end else if (accept) begin
          v_d     = in_data;
          i_d     = count_q;
          state_d = (count_q == '0) ? PLACE : READ;
        end
      end
      READ: begin
        mem_addr = LOGN'(i_q - ONE);
        state_d  = CMP;
      end
      CMP: begin
        // Strictly greater shifts; equal stops, so duplicates land after existing ones.
        if (mem_rd_data > v_q) begin
          mem_addr    = i_q[LOGN-1:0];
          mem_wr_en   = 1'b1;
          mem_wr_data = mem_rd_data;
          i_d         = i_q - ONE;
          state_d     = (i_q == ONE) ? PLACE : READ;
        end else begin
          state_d = PLACE;
        end
      end
      PLACE: begin
        mem_addr    = i_q[LOGN-1:0];
        mem_wr_en   = 1'b1;
        mem_wr_data = v_q;
        done        = 1'b1;
        count_d     = count_q + ONE;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes come straight from state, so suppress them while reset is being sampled.
    if (reset) begin
      mem_addr  = '0;
      mem_wr_en = 1'b0;
      done      = 1'b0;
    end

    full_d = (count_d == FULL_CNT);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      v_q     <= '0;
      i_q     <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      i_q     <= i_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sorted_insert_writer.sv
// Directed bench for sorted_insert_writer driving a sorted_ram model.
module tb_sorted_insert_writer;

  localparam int unsigned N    = 32;
  localparam int unsigned LOGN = 5;
  localparam int unsigned W    = 8;

  logic            clk;
  logic            reset;
  logic [W-1:0]    in_data;
  logic            in_valid;
  logic            in_ready;
  logic            clear;
  logic [LOGN-1:0] mem_addr;
  logic            mem_wr_en;
  logic [W-1:0]    mem_wr_data;
  logic [W-1:0]    mem_rd_data;
  logic [LOGN:0]   count;
  logic            full;
  logic            busy;
  logic            done;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  sorted_insert_writer #(.N(N), .LOGN(LOGN), .W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .clear       (clear),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .count       (count),
    .full        (full),
    .busy        (busy),
    .done        (done)
  );

  sorted_ram #(.N(N), .LOGN(LOGN), .W(W)) u_ram (
    .clk     (clk),
    .addr    (mem_addr),
    .wr_en   (mem_wr_en),
    .wr_data (mem_wr_data),
    .rd_data (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Handshake in cycle 0, then measure the cycle in which done pulses.
  task automatic do_insert(input logic [W-1:0] val, input int exp_cyc, input string tag);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    in_data  = val;
    in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else cyc++;
    end
    check({tag, "_done_cycle"}, cyc, exp_cyc);
    @(posedge clk); #1;
  endtask

  initial begin
    int snap;
    reset    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    clear    = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_ready", in_ready, 1);

    // Empty insert, then mixed sequence 5,3,9,3
    do_insert(8'd5, 1, "empty5");
    check("empty_mem0", u_ram.mem[0], 5);
    check("empty_count", count, 1);
    do_insert(8'd3, 3, "mix3a");
    do_insert(8'd9, 3, "mix9");
    do_insert(8'd3, 7, "mix3b");
    check("mix_mem0", u_ram.mem[0], 3);
    check("mix_mem1", u_ram.mem[1], 3);
    check("mix_mem2", u_ram.mem[2], 5);
    check("mix_mem3", u_ram.mem[3], 9);
    check("mix_count", count, 4);

    // Reset during the second CMP of inserting 0 into {3,3,5,9}
    @(posedge clk); #1;
    in_data  = 8'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rmid_wr_en", mem_wr_en, 0);
    check("rmid_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rmid_busy", busy, 0);
    check("rmid_count", count, 0);
    check("rmid_mem4", u_ram.mem[4], 9);
    check("rmid_mem3", u_ram.mem[3], 9);
    do_insert(8'd8, 1, "rmid8");
    check("rmid8_mem0", u_ram.mem[0], 8);
    check("rmid8_count", count, 1);

    // Duplicates: only the placing writes, no shifts
    do_reset();
    snap = wr_cnt;
    do_insert(8'd7, 1, "dup1");
    do_insert(8'd7, 3, "dup2");
    do_insert(8'd7, 3, "dup3");
    check("dup_writes", wr_cnt - snap, 3);
    check("dup_mem0", u_ram.mem[0], 7);
    check("dup_mem1", u_ram.mem[1], 7);
    check("dup_mem2", u_ram.mem[2], 7);
    check("dup_count", count, 3);

    // Clear together with a handshake: clear wins
    @(posedge clk); #1;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd44;
    @(negedge clk);
    check("clr_ready", in_ready, 0);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_count", count, 0);
    check("clr_busy", busy, 0);
    do_insert(8'd50, 1, "clr50");
    check("clr_mem0", u_ram.mem[0], 50);
    check("clr_count1", count, 1);

    // Fill to full with 32 down to 1; each lands at the bottom
    do_reset();
    for (int v = 32; v >= 1; v--) begin
      do_insert(W'(v), (v == 32) ? 1 : 1 + 2 * (32 - v), $sformatf("fill%0d", v));
    end
    for (int j = 0; j < 32; j++) begin
      check($sformatf("fill_mem%0d", j), u_ram.mem[j], j + 1);
    end
    @(negedge clk);
    check("fill_count", count, 32);
    check("fill_full", full, 1);
    check("fill_ready", in_ready, 0);

    // A held 33rd value is never accepted
    snap = wr_cnt;
    @(posedge clk); #1;
    in_data  = 8'd77;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_ready", in_ready, 0);
      check("hold_busy", busy, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_writes", wr_cnt - snap, 0);
    check("hold_count", count, 32);
    check("hold_mem0", u_ram.mem[0], 1);
    check("hold_mem31", u_ram.mem[31], 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
